// File: rtl/bnn_pkg.sv
// bnn_pkg: types and constants shared by the BNN sequencer and datapath blocks.
// Datapath blocks import seq_state_t to decode the exported 3-bit state code
// instead of comparing literals.
package bnn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_L1    = 3'd2,
        ST_L2    = 3'd3,
        ST_L3    = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } seq_state_t;

    localparam int NUM_CLASSES = 10;
    localparam int CLASS_W     = 4;

    // Layer completion interface: one done strobe per working stage, in
    // the order load, layer one, layer two, flatten.
    localparam int NUM_DONE    = 4;
    localparam int DONE_LOAD   = 0;
    localparam int DONE_L1     = 1;
    localparam int DONE_L2     = 2;
    localparam int DONE_L3     = 3;

    // Stages where the datapath is doing work and the sequencer waits on a done.
    function automatic logic is_working(seq_state_t s);
        return (s == ST_LOAD) || (s == ST_L1) || (s == ST_L2) || (s == ST_L3);
    endfunction

endpackage

// File: rtl/bnn_stage_watchdog.sv
// bnn_stage_watchdog: dwell counter for one sequencer state.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   clear       - state is changing this cycle; restart the count
//   count_en    - current state is a working state
//   timeout     - count has reached WDOG_CYCLES-1 while working
module bnn_stage_watchdog #(
    parameter int WDOG_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic timeout
);

    localparam int CNT_W = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WDOG_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (count_en && cnt_q != LIMIT)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // Count starts at 0 on state entry, so the limit is hit in the
    // WDOG_CYCLES-th cycle spent in the state.
    assign timeout = count_en && (cnt_q == LIMIT);

endmodule

// File: rtl/bnn_layer_sequencer.sv
// bnn_layer_sequencer: top-level inference controller for the MNIST BNN.
// Walks IDLE -> LOAD -> L1 -> L2 -> L3 -> DONE on done handshakes, pulses the
// per-stage start strobes, and latches the class answer.
// Optional per-stage watchdog: define BNN_SEQ_WATCHDOG_EN to add a dwell
// counter that drops a stuck stage into ERROR and sets the sticky error flag.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   start, abort        - run request (level), return-to-idle (level)
//   load_done, layer*_done - stage completion strobes
//   class_in            - flatten answer, valid with layer3_done
//   state               - exported state code (seq_state_t)
//   load_en, busy       - state decodes
//   l1/l2/l3_start      - one-cycle pulses on stage entry
//   result, result_valid, error - registered status
module bnn_layer_sequencer
    import bnn_pkg::*;
#(
    parameter int WDOG_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               load_done,
    input  logic               layer1_done,
    input  logic               layer2_done,
    input  logic               layer3_done,
    input  logic [CLASS_W-1:0] class_in,
    output logic [2:0]         state,
    output logic               load_en,
    output logic               l1_start,
    output logic               l2_start,
    output logic               l3_start,
    output logic               busy,
    output logic               result_valid,
    output logic [CLASS_W-1:0] result,
    output logic               error
);

    if (WDOG_CYCLES < 2) begin : g_wdog_range_chk
        $error("WDOG_CYCLES must be at least 2");
    end

    seq_state_t         state_q, state_d;
    logic               first_q, first_d;
    logic [CLASS_W-1:0] result_q, result_d;
    logic               result_valid_q, result_valid_d;
    logic [NUM_DONE-1:0] done_vec;
    logic               entering;
    logic               timeout;
    logic               entering_load;

    assign done_vec = {layer3_done, layer2_done, layer1_done, load_done};

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
        end
    end

    // ---------------- next state ----------------
    // Each done is honoured only in its own state; a done always beats a
    // watchdog timeout raised in the same cycle.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (start) state_d = ST_LOAD;
                ST_LOAD:  if (done_vec[DONE_LOAD]) state_d = ST_L1;
                          else if (timeout) state_d = ST_ERROR;
                ST_L1:    if (done_vec[DONE_L1]) state_d = ST_L2;
                          else if (timeout) state_d = ST_ERROR;
                ST_L2:    if (done_vec[DONE_L2]) state_d = ST_L3;
                          else if (timeout) state_d = ST_ERROR;
                ST_L3:    if (done_vec[DONE_L3]) state_d = ST_DONE;
                          else if (timeout) state_d = ST_ERROR;
                ST_DONE:  state_d = ST_IDLE;
                ST_ERROR: if (start) state_d = ST_LOAD;
                default:  state_d = ST_IDLE;   // code 7 recovers
            endcase
        end
    end

    assign entering      = (state_d != state_q);
    assign entering_load = entering && (state_d == ST_LOAD);
    // First-cycle flag lets the start pulses decode from registers only.
    assign first_d       = entering;

    // ---------------- outputs ----------------
    always_comb begin
        state    = state_q;
        load_en  = (state_q == ST_LOAD);
        busy     = is_working(state_q);
        l1_start = (state_q == ST_L1) && first_q;
        l2_start = (state_q == ST_L2) && first_q;
        l3_start = (state_q == ST_L3) && first_q;
    end

    // ---------------- result latch ----------------
    always_comb begin
        result_d       = result_q;
        result_valid_d = result_valid_q;
        if (entering_load) begin
            result_d       = '0;
            result_valid_d = 1'b0;
        end else if (state_q == ST_L3 && state_d == ST_DONE) begin
            result_d       = class_in;
            result_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;

`ifdef BNN_SEQ_WATCHDOG_EN
    logic error_q, error_d;

    bnn_stage_watchdog #(
        .WDOG_CYCLES(WDOG_CYCLES)
    ) u_wdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (entering),
        .count_en (is_working(state_q)),
        .timeout  (timeout)
    );

    // Sticky: abort leaves it alone, only ERROR -> LOAD clears it.
    always_comb begin
        error_d = error_q;
        if (state_d == ST_ERROR && state_q != ST_ERROR)
            error_d = 1'b1;
        else if (state_q == ST_ERROR && state_d == ST_LOAD)
            error_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            error_q <= 1'b0;
        else
            error_q <= error_d;
    end

    assign error = error_q;
`else
    assign timeout = 1'b0;
    assign error   = 1'b0;
`endif

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Bench for bnn_layer_sequencer: table vectors, directed corner sequences and
// randomized traffic against a stage-index reference model.
module tb_bnn_layer_sequencer;

    localparam int WDOG = 16;

    logic       clk = 1'b0;
    logic       reset, start, abort, load_done, layer1_done, layer2_done, layer3_done;
    logic [3:0] class_in;
    logic [2:0] state;
    logic       load_en, l1_start, l2_start, l3_start, busy, result_valid, error;
    logic [3:0] result;

    int nvec = 0;
    int nerr = 0;

    bnn_layer_sequencer #(.WDOG_CYCLES(WDOG)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .load_done(load_done), .layer1_done(layer1_done),
        .layer2_done(layer2_done), .layer3_done(layer3_done),
        .class_in(class_in), .state(state), .load_en(load_en),
        .l1_start(l1_start), .l2_start(l2_start), .l3_start(l3_start),
        .busy(busy), .result_valid(result_valid), .result(result), .error(error)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Stage index: 0 idle, 1..4 waiting on done[index-1], 5 done, 6 error.
    int         m_st = 0;
    bit         m_first = 0;
    logic [3:0] m_res = 0;
    bit         m_rv = 0, m_err = 0;
    int         m_dwell = 0;

    task automatic model_edge();
        int nxt;
        bit to;
        bit dn [4];
        dn = '{load_done, layer1_done, layer2_done, layer3_done};
        if (reset) begin
            m_st = 0; m_first = 0; m_res = 0; m_rv = 0; m_err = 0; m_dwell = 0;
            return;
        end
        to  = 0;
`ifdef BNN_SEQ_WATCHDOG_EN
        to = (m_st >= 1 && m_st <= 4 && m_dwell >= WDOG - 1);
`endif
        nxt = m_st;
        if (abort) nxt = 0;
        else if (m_st == 0 || m_st == 6) begin
            if (start) nxt = 1;
        end else if (m_st >= 1 && m_st <= 4) begin
            if (dn[m_st-1]) begin
                nxt = m_st + 1;
                if (m_st == 4) begin m_res = class_in; m_rv = 1; end
            end else if (to) begin
                nxt = 6; m_err = 1;
            end
        end else nxt = 0;
        if (nxt == 1 && m_st != 1) begin
            m_res = 0; m_rv = 0;
            if (m_st == 6) m_err = 0;
        end
        m_first = (nxt != m_st);
        m_dwell = (nxt != m_st) ? 0 : m_dwell + 1;
        m_st    = nxt;
    endtask

    function automatic logic [13:0] pack(logic [2:0] s, logic le, logic p1, logic p2, logic p3,
                                         logic b, logic rv, logic [3:0] r, logic e);
        return {s, le, p1, p2, p3, b, rv, r, e};
    endfunction

    function automatic logic [13:0] model_vec();
        return pack(3'(m_st), m_st == 1, m_st == 2 && m_first, m_st == 3 && m_first,
                    m_st == 4 && m_first, m_st >= 1 && m_st <= 4, m_rv, m_res, m_err);
    endfunction

    function automatic logic [13:0] dut_vec();
        return pack(state, load_en, l1_start, l2_start, l3_start, busy, result_valid, result, error);
    endfunction

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: model and DUT both consume the current inputs.
    task automatic cyc(input string name);
        model_edge();
        @(posedge clk);
        #1;
        check(name, dut_vec(), model_vec());
    endtask

    task automatic clr_in();
        reset = 0; start = 0; abort = 0;
        load_done = 0; layer1_done = 0; layer2_done = 0; layer3_done = 0;
        class_in = 0;
    endtask

    task automatic idle(input int n, input string name);
        clr_in();
        for (int i = 0; i < n; i++) cyc(name);
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic       rst, abrt, st, ld, d1, d2, d3;
        logic [3:0] cls;
        logic [2:0] e_state;
        logic       e_load, e_l1, e_l2, e_l3, e_busy, e_rv;
        logic [3:0] e_res;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int p1, p2, p3;
        logic [3:0] held;
        int done_idx, load_idx;
        logic [2:0] hist [16];
        logic       rvh  [16];

        tbl[0]  = '{1,0,0,0,0,0,0,0, 0, 0,0,0,0,0, 0,0};
        tbl[1]  = '{0,0,1,0,0,0,0,0, 1, 1,0,0,0,1, 0,0};
        tbl[2]  = '{0,0,0,1,0,0,0,0, 2, 0,1,0,0,1, 0,0};
        tbl[3]  = '{0,0,0,0,1,0,0,0, 3, 0,0,1,0,1, 0,0};
        tbl[4]  = '{0,0,0,0,0,1,0,0, 4, 0,0,0,1,1, 0,0};
        tbl[5]  = '{0,0,0,0,0,0,1,9, 5, 0,0,0,0,0, 1,9};
        tbl[6]  = '{0,0,0,0,0,0,0,0, 0, 0,0,0,0,0, 1,9};
        tbl[7]  = '{0,0,0,0,0,1,0,0, 0, 0,0,0,0,0, 1,9};
        tbl[8]  = '{0,0,1,0,0,0,0,0, 1, 1,0,0,0,1, 0,0};
        tbl[9]  = '{0,1,0,1,0,0,0,0, 0, 0,0,0,0,0, 0,0};
        tbl[10] = '{0,0,1,0,1,0,0,0, 1, 1,0,0,0,1, 0,0};
        tbl[11] = '{0,0,0,1,0,0,0,0, 2, 0,1,0,0,1, 0,0};
        tbl[12] = '{0,0,0,0,0,0,0,0, 2, 0,0,0,0,1, 0,0};
        tbl[13] = '{0,0,0,0,0,0,1,3, 2, 0,0,0,0,1, 0,0};

        clr_in();
        reset = 1;
        for (int i = 0; i < 14; i++) begin
            reset = tbl[i].rst; abort = tbl[i].abrt; start = tbl[i].st;
            load_done = tbl[i].ld; layer1_done = tbl[i].d1;
            layer2_done = tbl[i].d2; layer3_done = tbl[i].d3; class_in = tbl[i].cls;
            cyc("table_model");
            check($sformatf("table[%0d]", i), dut_vec(),
                  pack(tbl[i].e_state, tbl[i].e_load, tbl[i].e_l1, tbl[i].e_l2, tbl[i].e_l3,
                       tbl[i].e_busy, tbl[i].e_rv, tbl[i].e_res, 1'b0));
        end
        clr_in(); abort = 1; cyc("table_abort");

        // ---- nominal run: load_done after 10 LOAD cycles, dones 3 cycles after pulses
        p1 = 0; p2 = 0; p3 = 0;
        clr_in(); start = 1; cyc("nom_start");
        clr_in();
        for (int i = 0; i < 9; i++) cyc("nom_load");
        load_done = 1; cyc("nom_ld"); load_done = 0;
        p1 += l1_start;
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 2; i++) begin
                cyc("nom_wait"); p1 += l1_start; p2 += l2_start; p3 += l3_start;
            end
            if (s == 0) layer1_done = 1;
            if (s == 1) layer2_done = 1;
            if (s == 2) begin layer3_done = 1; class_in = 7; end
            cyc("nom_done");
            p1 += l1_start; p2 += l2_start; p3 += l3_start;
            clr_in();
        end
        check_bit("nom_l1_pulses", p1, 1);
        check_bit("nom_l2_pulses", p2, 1);
        check_bit("nom_l3_pulses", p3, 1);
        check("nom_done_state", dut_vec(), pack(3'd5, 0,0,0,0,0, 1, 4'd7, 0));
        cyc("nom_idle");
        check("nom_held", dut_vec(), pack(3'd0, 0,0,0,0,0, 1, 4'd7, 0));

        // ---- stray layer2_done in LOAD is not remembered
        clr_in(); start = 1; cyc("stray_start");
        clr_in(); layer2_done = 1; cyc("stray_l2_in_load");
        check_bit("stray_still_load", state, 1);
        clr_in(); load_done = 1; cyc("stray_ld");
        clr_in(); layer1_done = 1; cyc("stray_d1");
        clr_in(); cyc("stray_wait");
        cyc("stray_wait2");
        check_bit("stray_l2_waits", state, 3);

        // ---- abort in L2 together with layer2_done
        held = result;
        clr_in(); abort = 1; layer2_done = 1; cyc("abort_l2");
        check_bit("abort_state", state, 0);
        check_bit("abort_no_l3", l3_start, 0);
        check_bit("abort_result", result, held);
        idle(2, "abort_after");

        // ---- watchdog: no layer1_done
        clr_in(); start = 1; cyc("wd_start");
        clr_in(); load_done = 1; cyc("wd_ld");
        clr_in();
        for (int i = 0; i < 15; i++) cyc("wd_dwell");
        check_bit("wd_last_l1", state, 2);
        cyc("wd_edge");
`ifdef BNN_SEQ_WATCHDOG_EN
        check_bit("wd_error_state", state, 6);
        check_bit("wd_error_flag", error, 1);
        clr_in(); start = 1; cyc("wd_restart");
        check_bit("wd_restart_load", state, 1);
        check_bit("wd_error_clear", error, 0);
`else
        check_bit("wd_off_stays", state, 2);
        for (int i = 0; i < 20; i++) cyc("wd_off_hang");
        check_bit("wd_off_still_l1", state, 2);
        check_bit("wd_off_no_error", error, 0);
`endif
        clr_in(); abort = 1; cyc("wd_abort");

        // ---- reset in L3 with layer3_done
        clr_in(); start = 1; cyc("rst_start");
        clr_in(); load_done = 1; cyc("rst_ld");
        clr_in(); layer1_done = 1; cyc("rst_d1");
        clr_in(); layer2_done = 1; cyc("rst_d2");
        clr_in(); reset = 1; layer3_done = 1; class_in = 5; cyc("rst_in_l3");
        check("rst_all_zero", dut_vec(), 14'd0);

        // ---- back-to-back runs: start and all dones held high
        clr_in(); start = 1; load_done = 1; layer1_done = 1; layer2_done = 1;
        layer3_done = 1; class_in = 4;
        for (int i = 0; i < 16; i++) begin
            cyc("b2b");
            hist[i] = state; rvh[i] = result_valid;
        end
        done_idx = -1; load_idx = -1;
        for (int i = 0; i < 16; i++)
            if (done_idx < 0 && hist[i] == 3'd5) done_idx = i;
        for (int i = 0; i < 16; i++)
            if (load_idx < 0 && done_idx >= 0 && i > done_idx && hist[i] == 3'd1) load_idx = i;
        check_bit("b2b_gap", load_idx - done_idx, 2);
        check_bit("b2b_rv_in_done", (done_idx >= 0) ? int'(rvh[done_idx]) : -1, 1);
        check_bit("b2b_rv_drop", (load_idx >= 0) ? int'(rvh[load_idx]) : -1, 0);

        // ---- randomized traffic against the model
        clr_in(); reset = 1; cyc("rnd_reset");
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 199) == 0);
            abort       = ($urandom_range(0, 39) == 0);
            start       = ($urandom_range(0, 2) == 0);
            load_done   = ($urandom_range(0, 3) == 0);
            layer1_done = ($urandom_range(0, 3) == 0);
            layer2_done = ($urandom_range(0, 3) == 0);
            layer3_done = ($urandom_range(0, 3) == 0);
            class_in    = 4'($urandom_range(0, 9));
            cyc("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
